// File: rtl/riscv_v_pkg.sv
// riscv_v_pkg
// Shared definitions for the vector bitwise-unit reduction path:
//   - datapath width and element-size encoding width
//   - bitwise combine op encoding (riscv_v_bw_op_e)
//   - one-hot element-size constants and width_mask() helper
//   - reduction accumulator state encoding
package riscv_v_pkg;

    localparam int RISCV_V_DATA_WIDTH       = 128;
    localparam int RISCV_V_NUM_VALID_OSIZES = 5;

    typedef enum logic [1:0] {
        BW_AND  = 2'b00,
        BW_OR   = 2'b01,
        BW_XOR  = 2'b10,
        BW_RSVD = 2'b11
    } riscv_v_bw_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_FULL  = 2'b10
    } riscv_v_reduct_state_e;

    localparam logic [RISCV_V_NUM_VALID_OSIZES-1:0] OSIZE_8B   = 5'b00001;
    localparam logic [RISCV_V_NUM_VALID_OSIZES-1:0] OSIZE_16B  = 5'b00010;
    localparam logic [RISCV_V_NUM_VALID_OSIZES-1:0] OSIZE_32B  = 5'b00100;
    localparam logic [RISCV_V_NUM_VALID_OSIZES-1:0] OSIZE_64B  = 5'b01000;
    localparam logic [RISCV_V_NUM_VALID_OSIZES-1:0] OSIZE_128B = 5'b10000;

    // Low-order ones covering one element; a malformed (non-one-hot) size
    // keeps the full beat so no data is silently dropped.
    function automatic logic [RISCV_V_DATA_WIDTH-1:0] width_mask(
        input logic [RISCV_V_NUM_VALID_OSIZES-1:0] osize
    );
        logic [RISCV_V_DATA_WIDTH-1:0] ones;
        ones = {RISCV_V_DATA_WIDTH{1'b1}};
        case (osize)
            OSIZE_8B:   width_mask = ones >> (RISCV_V_DATA_WIDTH - 32'd8);
            OSIZE_16B:  width_mask = ones >> (RISCV_V_DATA_WIDTH - 32'd16);
            OSIZE_32B:  width_mask = ones >> (RISCV_V_DATA_WIDTH - 32'd32);
            OSIZE_64B:  width_mask = ones >> (RISCV_V_DATA_WIDTH - 32'd64);
            OSIZE_128B: width_mask = ones;
            default:    width_mask = ones;
        endcase
    endfunction

endpackage

// File: rtl/riscv_v_reduct_combine.sv
// riscv_v_reduct_combine
// Combinational combine step of the reduction accumulator.
// Ports:
//   acc     - current partial (already masked to element width)
//   operand - incoming bitwise-unit result beat
//   op      - AND / OR / XOR / reserved (reserved replaces)
//   osize   - one-hot element size selecting the mask
//   start   - beat opens a new group: result is the masked operand alone
//   result  - next partial / final value, zero above element width
module riscv_v_reduct_combine
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
    parameter int NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES
) (
    input  logic [DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0] operand,
    input  riscv_v_bw_op_e        op,
    input  logic [NUM_OSIZES-1:0] osize,
    input  logic                  start,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] mask_s;
    logic [DATA_WIDTH-1:0] masked_s;

    assign mask_s   = DATA_WIDTH'(width_mask(RISCV_V_NUM_VALID_OSIZES'(osize)));
    assign masked_s = operand & mask_s;

    // Apply the latched op; a group start or the reserved op overwrites the partial
    always_comb begin
        result = masked_s;
        if (start) begin
            result = masked_s;
        end else begin
            case (op)
                BW_AND:  result = acc & masked_s;
                BW_OR:   result = acc | masked_s;
                BW_XOR:  result = acc ^ masked_s;
                BW_RSVD: result = masked_s;
                default: result = masked_s;
            endcase
        end
    end

endmodule

// File: rtl/riscv_v_bw_reduct_acc.sv
// riscv_v_bw_reduct_acc
// Collects bitwise-unit result beats, folds reduction groups into a single
// element-width value and presents results through a one-entry output
// register with valid/ready handshake on both sides.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready             - input beat handshake
//   in_result                     - beat data
//   in_is_reduct/in_first/in_last - reduction group framing
//   in_op, in_osize               - combine op and one-hot element size
//   out_valid/out_ready           - result handshake
//   out_data, out_nbeats          - result value and beats folded (sat. 15)
//   err_restart                   - one-cycle pulse when a partial is abandoned
module riscv_v_bw_reduct_acc
    import riscv_v_pkg::*;
#(
    parameter int DATA_WIDTH = RISCV_V_DATA_WIDTH,
    parameter int NUM_OSIZES = RISCV_V_NUM_VALID_OSIZES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_is_reduct,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [1:0]            in_op,
    input  logic [NUM_OSIZES-1:0] in_osize,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [3:0]            out_nbeats,
    output logic                  err_restart
);

    riscv_v_reduct_state_e state_r, state_s;
    logic [DATA_WIDTH-1:0] acc_r, acc_s;
    logic [3:0]            cnt_r, cnt_s;
    logic [NUM_OSIZES-1:0] osize_r, osize_s;
    riscv_v_bw_op_e        op_r, op_s;
    logic                  out_valid_r, out_valid_s;
    logic [DATA_WIDTH-1:0] out_data_r, out_data_s;
    logic [3:0]            out_nbeats_r, out_nbeats_s;
    logic                  err_r, err_s;

    logic                  accept_s;
    logic                  start_s;
    riscv_v_bw_op_e        op_sel_s;
    logic [NUM_OSIZES-1:0] osize_sel_s;
    logic [DATA_WIDTH-1:0] combined_s;
    logic [3:0]            cnt_inc_s;

    // The output register can take a new beat only when it is empty or draining this cycle.
    assign in_ready = (state_r != ST_FULL) || out_ready;
    assign accept_s = in_valid && in_ready;

    // Any reduct beat that does not land on a live partial opens a new group.
    assign start_s     = in_first || (state_r != ST_ACCUM);
    assign op_sel_s    = start_s ? riscv_v_bw_op_e'(in_op) : op_r;
    assign osize_sel_s = start_s ? in_osize : osize_r;
    assign cnt_inc_s   = start_s ? 4'd1 : ((cnt_r == 4'd15) ? 4'd15 : (cnt_r + 4'd1));

    riscv_v_reduct_combine #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_OSIZES (NUM_OSIZES)
    ) u_combine (
        .acc     (acc_r),
        .operand (in_result),
        .op      (op_sel_s),
        .osize   (osize_sel_s),
        .start   (start_s),
        .result  (combined_s)
    );

    // Next-state and next-register values for the accumulator FSM
    always_comb begin
        state_s      = state_r;
        acc_s        = acc_r;
        cnt_s        = cnt_r;
        osize_s      = osize_r;
        op_s         = op_r;
        out_valid_s  = out_valid_r;
        out_data_s   = out_data_r;
        out_nbeats_s = out_nbeats_r;
        err_s        = 1'b0;

        // Drain of the output register; a partial is never pending in FULL
        case (state_r)
            ST_FULL: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            ST_IDLE:  state_s = ST_IDLE;
            ST_ACCUM: state_s = ST_ACCUM;
            default:  state_s = ST_IDLE;
        endcase

        if (accept_s) begin
            if (!in_is_reduct) begin
                out_data_s   = in_result;
                out_nbeats_s = 4'd1;
                out_valid_s  = 1'b1;
                state_s      = ST_FULL;
                acc_s        = {DATA_WIDTH{1'b0}};
                cnt_s        = 4'd0;
                err_s        = (state_r == ST_ACCUM);
            end else begin
                err_s = in_first && (state_r == ST_ACCUM);
                if (in_last) begin
                    out_data_s   = combined_s;
                    out_nbeats_s = cnt_inc_s;
                    out_valid_s  = 1'b1;
                    state_s      = ST_FULL;
                    acc_s        = {DATA_WIDTH{1'b0}};
                    cnt_s        = 4'd0;
                end else begin
                    acc_s   = combined_s;
                    cnt_s   = cnt_inc_s;
                    osize_s = osize_sel_s;
                    op_s    = op_sel_s;
                    state_s = ST_ACCUM;
                end
            end
        end else begin
            err_s = 1'b0;
        end
    end

    // State, accumulator and output registers; reset wins over any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            acc_r        <= {DATA_WIDTH{1'b0}};
            cnt_r        <= 4'd0;
            osize_r      <= {NUM_OSIZES{1'b0}};
            op_r         <= BW_AND;
            out_valid_r  <= 1'b0;
            out_data_r   <= {DATA_WIDTH{1'b0}};
            out_nbeats_r <= 4'd0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            acc_r        <= acc_s;
            cnt_r        <= cnt_s;
            osize_r      <= osize_s;
            op_r         <= op_s;
            out_valid_r  <= out_valid_s;
            out_data_r   <= out_data_s;
            out_nbeats_r <= out_nbeats_s;
            err_r        <= err_s;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_nbeats  = out_nbeats_r;
    assign err_restart = err_r;

endmodule

// File: doc/riscv_v_bw_reduct_acc.md
RISCV_V_BW_REDUCT_ACC -- requirements
Module: riscv_v_bw_reduct_acc

Interface
REQ-001 Parameter DATA_WIDTH, default 128 (RISCV_V_DATA_WIDTH): result beat width.
REQ-002 Parameter NUM_OSIZES, default 5 (RISCV_V_NUM_VALID_OSIZES): one-hot element-size encoding width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream bitwise-unit beat valid.
REQ-006 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 in_result  input  DATA_WIDTH  bitwise-unit result beat.
REQ-008 in_is_reduct  input  1  beat belongs to a reduction.
REQ-009 in_first  input  1  first beat of a reduction group.
REQ-010 in_last  input  1  last beat of a reduction group.
REQ-011 in_op  input  2  combine op: 00 AND, 01 OR, 10 XOR, 11 reserved.
REQ-012 in_osize  input  NUM_OSIZES  one-hot element size: bit0 8b, bit1 16b, bit2 32b, bit3 64b, bit4 128b.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-015 out_data  output  DATA_WIDTH  final result.
REQ-016 out_nbeats  output  4  beats combined into out_data, saturating at 15.
REQ-017 err_restart  output  1  one-cycle pulse: reduction group abandoned.

Function
REQ-018 States: IDLE (no partial), ACCUM (partial in acc), FULL (out_valid high, awaiting out_ready).
REQ-019 in_ready = 0 in FULL unless out_ready = 1 (pipeline-register rule); in_ready = 1 in IDLE and ACCUM.
REQ-020 Non-reduct beat accepted: out_data <= in_result unmodified, out_nbeats <= 1, out_valid high next cycle (latency 1), state -> FULL.
REQ-021 Reduct beat with in_first: acc <= in_result & width_mask(in_osize); osize and op latched; beat count <= 1.
REQ-022 Reduct beat without in_first, in ACCUM: acc <= acc OP (in_result & width_mask(latched osize)); count increments, saturating at 15.
REQ-023 Latched osize and op SHALL apply for the whole group; in_osize and in_op on non-first beats are ignored.
REQ-024 Reduct beat with in_last: out_data <= final combined value, zero above element width; out_nbeats <= count; state -> FULL; acc cleared.
REQ-025 in_first && in_last on the same beat: single-beat group; out_data = in_result & width_mask.
REQ-026 Reduct beat in IDLE without in_first: treated as in_first.
REQ-027 in_first while in ACCUM: partial discarded, new group started, err_restart pulses 1 cycle.
REQ-028 Non-reduct beat while in ACCUM: partial discarded, err_restart pulses, beat handled per REQ-020.
REQ-029 op 11: acc <= masked in_result (replace), no error.
REQ-030 In FULL with out_ready = 1 and new beat accepted: transfer and capture in the same cycle, out_valid stays high (no bubble).
REQ-031 In FULL with out_ready = 1 and no beat: state -> IDLE (or ACCUM if partial pending), out_valid low.
REQ-032 out_data and out_nbeats held stable while out_valid && !out_ready.

Reset
REQ-033 rst = 1 at a clk edge: state IDLE, out_valid 0, out_data 0, out_nbeats 0, acc 0, count 0, err_restart 0; takes priority over any handshake, including mid-group.
REQ-034 in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-035 Op encoding (riscv_v_bw_op_e), osize one-hot constants and width_mask function SHALL live in riscv_v_pkg.
REQ-036 Combine datapath SHALL be one sub-module riscv_v_reduct_combine (AND/OR/XOR/replace plus masking); state machine and registers in the top module.

Verification
REQ-037 Non-reduct beat 0xA5 repeated, out_ready = 1 -> out_data = beat one cycle later, out_nbeats = 1.
REQ-038 XOR, osize 8b, 4 beats with low bytes 0x01, 0x02, 0x04, 0x08 -> out_data = 0x0F, out_nbeats = 4, upper bits 0.
REQ-039 AND, osize 32b, single beat 0xFFFF_FFFF_1234_5678 (first && last) -> out_data = 0x1234_5678.
REQ-040 out_ready held 0 for 3 cycles after a result -> in_ready = 0, out_data stable; back-to-back beats accepted once out_ready = 1, with no bubble.
REQ-041 OR group, 2 beats, then in_first on the next beat -> err_restart pulses once; only the new group's value is output.
REQ-042 rst asserted mid-group after 2 XOR beats -> all outputs 0; a following single-beat group yields only its own value.
